// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host link plus the instruction-memory write port.
// Latency: none (pure signal bundle).
// Backpressure: rx_ready from the loader side throttles the byte source.
interface imem_loader_if #(
  parameter int ADDR_W = 7
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Byte source / memory observer side
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: 16-bit BE word count then N BE 32-bit words written to imem from address 0.
// Latency: write strobe the cycle after a word's 4th byte; CPU released the edge after the last write.
// Backpressure: rx_ready drops for the one-cycle WRITE state and stays low in DONE/ERR.
module imem_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128  // must equal 2**ADDR_W
) (
  input  logic          clkin,
  input  logic          reset,
  imem_loader_if.slave  bus,
  input  logic          load_req,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [23:0]       shift_q, shift_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;

  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       hdr_count;
  logic              last_word;

  // Ready only in byte-consuming states; forced low while reset is held
  assign bus.rx_ready = !reset &&
                        ((state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA));
  assign xfer      = bus.rx_valid && bus.rx_ready;
  // Full count as it will be once the low byte lands
  assign hdr_count = {count_q[15:8], bus.rx_data};
  // Word counter is compared against N-1; N>=1 is guaranteed once in DATA/WRITE
  assign last_word = (16'(word_cnt_q) == (count_q - 16'd1));

  // State register
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) state_q <= S_HDR_HI;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_HI: if (xfer) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (xfer) begin
          if (hdr_count == 16'd0)             state_d = S_DONE;
          else if (hdr_count > 16'(DEPTH))    state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      S_DATA:   if (xfer && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
      S_WRITE:  state_d = last_word ? S_DONE : S_DATA;
      S_DONE,
      S_ERR:    if (load_req) state_d = S_HDR_HI;
      default:  state_d = S_HDR_HI;
    endcase
  end

  // Datapath: header capture, byte assembly and word counting
  always_comb begin
    count_d    = count_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_HDR_HI: if (xfer) count_d[15:8] = bus.rx_data;
      S_HDR_LO: begin
        if (xfer) begin
          count_d[7:0] = bus.rx_data;
          word_cnt_d   = '0;
          byte_cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d    = {shift_q[15:0], bus.rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      S_WRITE:  word_cnt_d = word_cnt_q + ADDR_W'(1);
      S_DONE,
      S_ERR: begin
        if (load_req) begin
          count_d    = '0;
          shift_d    = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs derived from the state being entered
  always_comb begin
    imem_we_d    = (state_d == S_WRITE);
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    // Capture the word together with the 4th byte so WRITE presents it directly
    if ((state_q == S_DATA) && (state_d == S_WRITE)) begin
      imem_addr_d  = word_cnt_q;
      imem_wdata_d = {shift_q, bus.rx_data};
    end
    cpu_reset_d = (state_d != S_DONE);
    busy_d      = (state_d != S_DONE) && (state_d != S_ERR);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  // Datapath and output registers
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven, popped on imem_we.
// Latency: n/a.
// Backpressure: byte driver holds each byte until rx_ready is seen at the accepting edge.
module tb_imem_loader;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  logic load_req = 1'b0;
  logic cpu_reset, busy, done, err;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  logic [38:0] exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clkin    (clkin),
    .reset    (reset),
    .bus      (bus.slave),
    .load_req (load_req),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clkin = ~clkin;

  // Write monitor: every strobe must match the oldest queued expectation
  always @(negedge clkin) begin
    if (!reset && bus.imem_we === 1'b1) begin
      logic [38:0] want;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%08h required=no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        want = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== want) begin
          failures++;
          $display("FAIL write_value addr=%0d data=%08h required addr=%0d data=%08h",
                   bus.imem_addr, bus.imem_wdata, want[38:32], want[31:0]);
        end
      end
      checks++;
      if (bus.rx_ready !== 1'b0) begin
        failures++;
        $display("FAIL write_rx_ready got=%b required=0", bus.rx_ready);
      end
    end
  end

  // Present one byte and hold it until it transfers; optional idle gaps with junk data
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 0;
    int tmo = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 3)) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        @(posedge clkin); #1;
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!acc && tmo < 50) begin
      @(negedge clkin);
      acc = bus.rx_ready;
      @(posedge clkin); #1;
      tmo++;
    end
    bus.rx_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL byte_timeout byte=%02h got=not accepted required=accepted", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], rnd);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clkin); #1;
    load_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clkin); n++; end
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    repeat (2) @(negedge clkin);
    checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b required=0", bus.imem_we); end
    checks++; if (bus.imem_addr !== 7'd0) begin failures++; $display("FAIL rst_addr got=%0d required=0", bus.imem_addr); end
    checks++; if (bus.imem_wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%08h required=0", bus.imem_wdata); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset got=%b required=1", cpu_reset); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b required=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b required=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b required=0", err); end
    checks++; if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%b required=0", bus.rx_ready); end
    @(posedge clkin); #1;
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clkin);
    checks++; if (bus.rx_ready !== 1'b1) begin failures++; $display("FAIL post_rst_rx_ready got=%b required=1", bus.rx_ready); end
    @(posedge clkin); #1;
  endtask

  task automatic test_normal_load();
    wr_count = 0;
    exp_q.push_back({7'd0, 32'h20080005});
    exp_q.push_back({7'd1, 32'h08000000});
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(32'h20080005, 0);
    send_word(32'h08000000, 0);
    @(negedge clkin);
    checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 7'd1) begin failures++; $display("FAIL last_write_cycle we=%b addr=%0d required we=1 addr=1", bus.imem_we, bus.imem_addr); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL cpu_reset_during_write got=%b required=1", cpu_reset); end
    @(negedge clkin);
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL cpu_release got=%b required=0", cpu_reset); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL normal_done done=%b busy=%b required done=1 busy=0", done, busy); end
    checks++; if (wr_count !== 2 || exp_q.size() !== 0) begin failures++; $display("FAIL normal_writes count=%0d pending=%0d required 2/0", wr_count, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    pulse_load();
    @(negedge clkin);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin failures++; $display("FAIL reload busy=%b done=%b cpu_reset=%b required 1/0/1", busy, done, cpu_reset); end
    wr_count = 0;
    exp_q.push_back({7'd0, 32'h20080005});
    exp_q.push_back({7'd1, 32'h08000000});
    send_byte(8'h00, 1); send_byte(8'h02, 1);
    send_word(32'h20080005, 1);
    send_word(32'h08000000, 1);
    wait_done(20);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b required=1", done); end
    checks++; if (wr_count !== 2 || exp_q.size() !== 0) begin failures++; $display("FAIL bp_writes count=%0d pending=%0d required 2/0", wr_count, exp_q.size()); end
  endtask

  task automatic test_zero_count();
    pulse_load();
    wr_count = 0;
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clkin);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin failures++; $display("FAIL zero_done done=%b cpu_reset=%b required 1/0", done, cpu_reset); end
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    repeat (3) begin
      @(negedge clkin);
      checks++; if (bus.rx_ready !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL done_ignores_rx rx_ready=%b done=%b required 0/1", bus.rx_ready, done); end
    end
    bus.rx_valid = 1'b0;
    checks++; if (wr_count !== 0) begin failures++; $display("FAIL zero_writes got=%0d required=0", wr_count); end
    @(posedge clkin); #1;
  endtask

  task automatic test_oversize();
    pulse_load();
    wr_count = 0;
    send_byte(8'h00, 0); send_byte(8'h81, 0);
    @(negedge clkin);
    checks++; if (err !== 1'b1 || cpu_reset !== 1'b1) begin failures++; $display("FAIL oversize_err err=%b cpu_reset=%b required 1/1", err, cpu_reset); end
    checks++; if (bus.rx_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL oversize_flags rx_ready=%b busy=%b done=%b required 0/0/0", bus.rx_ready, busy, done); end
    bus.rx_valid = 1'b1; bus.rx_data = 8'h12;
    repeat (3) @(negedge clkin);
    bus.rx_valid = 1'b0;
    checks++; if (wr_count !== 0 || err !== 1'b1) begin failures++; $display("FAIL oversize_hold writes=%0d err=%b required 0/1", wr_count, err); end
    @(posedge clkin); #1;
    pulse_load();
    @(negedge clkin);
    checks++; if (err !== 1'b0 || busy !== 1'b1 || bus.rx_ready !== 1'b1) begin failures++; $display("FAIL err_reload err=%b busy=%b rx_ready=%b required 0/1/1", err, busy, bus.rx_ready); end
    @(posedge clkin); #1;
  endtask

  task automatic test_full_depth();
    wr_count = 0;
    send_byte(8'h00, 0); send_byte(8'h80, 0);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back({7'(k), 32'(k)});
      send_word(32'(k), 0);
    end
    wait_done(10);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL full_done done=%b err=%b required 1/0", done, err); end
    checks++; if (wr_count !== DEPTH || exp_q.size() !== 0) begin failures++; $display("FAIL full_writes count=%0d pending=%0d required 128/0", wr_count, exp_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    pulse_load();
    wr_count = 0;
    exp_q.push_back({7'd0, 32'hA1B2C3D4});
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_word(32'hA1B2C3D4, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    #2;
    reset = 1'b1;
    load_req = 1'b1;
    #1;
    checks++; if (cpu_reset !== 1'b1 || bus.imem_we !== 1'b0) begin failures++; $display("FAIL mid_rst_outputs cpu_reset=%b we=%b required 1/0", cpu_reset, bus.imem_we); end
    checks++; if (bus.rx_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mid_rst_flags rx_ready=%b busy=%b required 0/1", bus.rx_ready, busy); end
    @(posedge clkin); #1;
    load_req = 1'b0;
    reset = 1'b0;
    @(negedge clkin);
    checks++; if (wr_count !== 1 || exp_q.size() !== 0) begin failures++; $display("FAIL mid_rst_writes count=%0d pending=%0d required 1/0", wr_count, exp_q.size()); end
    checks++; if (done !== 1'b0 || bus.rx_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_state done=%b rx_ready=%b required 0/1", done, bus.rx_ready); end
    @(posedge clkin); #1;
    wr_count = 0;
    exp_q.push_back({7'd0, 32'hDEADBEEF});
    exp_q.push_back({7'd1, 32'h01234567});
    exp_q.push_back({7'd2, 32'hCAFEF00D});
    send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_word(32'hDEADBEEF, 1);
    send_word(32'h01234567, 1);
    send_word(32'hCAFEF00D, 1);
    wait_done(20);
    checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin failures++; $display("FAIL reload_done done=%b cpu_reset=%b required 1/0", done, cpu_reset); end
    checks++; if (wr_count !== 3 || exp_q.size() !== 0) begin failures++; $display("FAIL reload_writes count=%0d pending=%0d required 3/0", wr_count, exp_q.size()); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_normal_load();
    test_backpressure();
    test_zero_count();
    test_oversize();
    test_full_depth();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle CPU only reads (the CPU fetches with word address pc[8:2]).
- Accepts a byte stream over a valid/ready handshake from a host link such as a UART receiver.
- Assembles the bytes into 32-bit instruction words and writes them sequentially from word address 0.
- Holds the CPU in reset until the image is fully written, then releases it.

Parameters:
- ADDR_W, 7, instruction memory word-address width; matches pc[8:2].
- DEPTH, 128, words available; must equal 2**ADDR_W.

Ports:
- clkin  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts rx_data this cycle.
- load_req  input  1  one-cycle pulse that requests a reload; honoured only in DONE or ERR.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  instruction memory word address.
- imem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  active-high reset for the CPU core.
- busy  output  1  load in progress.
- done  output  1  image loaded; CPU running.
- err  output  1  header word count exceeds DEPTH.

Behaviour:
- Byte transfer: a byte transfers when rx_valid && rx_ready at a posedge. rx_data may change freely when no transfer occurs.
- Stream format:
  - Header: 16-bit word count N, big-endian (count high byte first).
  - Payload: N words, 4 bytes each, most-significant byte first. The first byte lands in bits [31:24].
- States: HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR. Asynchronous reset forces HDR_HI.
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, busy=1, done=0, err=0.
  - rx_ready=0 while reset is asserted.
- rx_ready is combinational: 1 in HDR_HI, HDR_LO and DATA; 0 in WRITE, DONE and ERR. All other outputs are registered.
- HDR_HI: on transfer, latch count[15:8] and go to HDR_LO.
- HDR_LO: on transfer, latch count[7:0] and evaluate the full count:
  - N==0: go to DONE.
  - N>DEPTH: go to ERR.
  - Otherwise: clear the word counter and byte counter, then go to DATA.
- DATA:
  - Each transfer shifts the byte into the word shift register and increments the 2-bit byte counter.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=word counter, imem_wdata=assembled word.
  - The word counter increments at the end of the cycle.
  - If the word just written was word N-1, go to DONE; else return to DATA.
- Throughput: the maximum rate is 4 bytes per 5 cycles. The upstream source must hold the 5th byte while rx_ready=0.
- Word address: imem_addr never exceeds N-1. N==DEPTH writes addresses 0..DEPTH-1 with no wrap.
- DONE:
  - cpu_reset=0, busy=0, done=1.
  - cpu_reset deasserts on the same edge that enters DONE, i.e. the edge after the final imem_we cycle.
- ERR:
  - cpu_reset=1, busy=0, err=1.
  - Nothing is written to memory.
- load_req:
  - In DONE or ERR, a load_req pulse goes to HDR_HI on the next edge: cpu_reset=1, busy=1, done=0, err=0, counters cleared.
  - load_req in any other state is ignored.
- rx_valid outside the loading states: in DONE or ERR it is ignored and no byte is consumed.
- Reset mid-load: the load aborts immediately and the state returns to HDR_HI. Words already written remain in memory and are overwritten by the next load.
- Simultaneous reset and load_req: reset wins.

Test Plan:
- Normal load:
  - Stimulus: bytes 00 02 | 20 08 00 05 | 08 00 00 00 with rx_valid held high.
  - Response: imem_we at addr 0 with data 0x20080005, then at addr 1 with data 0x08000000.
  - rx_ready is low during each WRITE cycle.
  - cpu_reset falls one cycle after the 2nd write; done=1.
- Backpressure and gaps:
  - Stimulus: same stream with rx_valid toggled randomly.
  - Response: identical writes; no byte lost or duplicated.
- Zero count:
  - Stimulus: bytes 00 00.
  - Response: no imem_we; DONE entered the cycle after the 2nd byte; cpu_reset=0.
- Oversize count:
  - Stimulus: bytes 00 81 (N=129).
  - Response: err=1, cpu_reset=1, rx_ready=0, no writes.
  - A subsequent load_req returns to HDR_HI with err=0.
- Full depth:
  - Stimulus: N=128 with word k = 0x0000_0000+k.
  - Response: 128 writes at addr 0..127 with data k; no wrap; done=1.
- Reset mid-load:
  - Stimulus: assert reset after 6 payload bytes of a 3-word image.
  - Response: cpu_reset=1 and imem_we=0 immediately; only addr 0 was written; a fresh full stream then loads correctly.
